rr_stream_mux4: RTL and testbench
=================================

# rr_stream_mux4

Four-to-one streaming multiplexer with round-robin arbitration and packet locking, the merge counterpart to the team's 1:4 demultiplexer. It collects valid/ready beats from four source channels onto one registered output stream. The output is tagged with the 2-bit source index so a downstream 1:4 demux can route responses back. It sits between four producers and a single shared consumer, for example a shared bus port or a serializer.

## Interface
- WIDTH, default 8: data width per channel, in bits.
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  4: per-channel beat valid; bit k belongs to channel k.
- in_ready  out  4: per-channel accept; at most one bit high in any cycle.
- in_data  in  4*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- in_last  in  4: per-channel end-of-packet flag, qualified by in_valid.
- out_valid  out  1: output beat valid (registered).
- out_ready  in  1: downstream accept.
- out_data  out  WIDTH: registered data of the current output beat.
- out_sel  out  2: source channel index of the current output beat.
- out_last  out  1: end-of-packet flag of the current output beat.

## Operation
- Handshake: a transfer occurs on a channel when valid and ready are both high at a rising edge. A source must not drop in_valid or change in_data/in_last until accepted.
- Output register load enable: `load = ~out_valid | out_ready`. When load is high and a channel is granted with its in_valid high, the register captures that channel's data, last flag and index.
- `in_ready[k] = load & grant[k] & ~rst`.
- State machine, states ST_IDLE and ST_LOCK, with lock_ch (2 bits) and rr pointer ptr (2 bits):
  - ST_IDLE: grant goes to the first asserted in_valid, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    - Accepted beat with in_last=1: stay in ST_IDLE; ptr <= k+1 mod 4.
    - Accepted beat with in_last=0: go to ST_LOCK; lock_ch <= k.
  - ST_LOCK: grant goes only to lock_ch, regardless of other channels.
    - Accepted beat with in_last=1: go to ST_IDLE; ptr <= lock_ch+1 mod 4.
- A packet, meaning beats up to and including in_last=1, is never interleaved with another channel's beats.
- No in_valid asserted in ST_IDLE: no grant, no state change, ptr unchanged.
- ST_LOCK with the locked channel idle: bubble. The output goes empty once drained, and other channels stay blocked.
- out_valid high with out_ready low: out_data/out_sel/out_last hold stable, and in_ready is all zeros.
- out_valid high with out_ready high and a granted beat present: the new beat is loaded in the same cycle, so out_valid stays high. This gives 1 beat/cycle throughput.
- out_valid high with out_ready high and no granted beat: out_valid clears next cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, state=ST_IDLE, ptr=0, lock_ch=0. in_ready=0 while rst is high.
- Reset mid-packet: the lock is dropped and any buffered output beat is discarded. The next grant follows priority order 0,1,2,3.
- Latency: a beat accepted at edge N appears on out_* right after edge N and is valid in cycle N+1.
- in_ready is combinational from state, ptr, in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- Sustained throughput is 1 beat/cycle under continuous out_ready. With all four channels sending single-beat packets, grants rotate 0,1,2,3,0 with no gaps.

## Structure
- Shared package rr_stream_mux4_pkg holds:
  - NUM_CH=4 and SEL_W=2;
  - the state enum {ST_IDLE, ST_LOCK}.
- One sub-module, rr_pick4: purely combinational rotating priority picker.
  - Inputs: 4-bit request and 2-bit ptr.
  - Outputs: one-hot grant, 2-bit index and any-grant flag.
- The top level holds the FSM, ptr/lock registers, output register and in_data slicing.

## Test plan
- Reset check: assert rst with all in_valid high.
  - During reset: in_ready=0 and out_valid=0.
  - First cycle after release: in_ready=4'b0001, and out_sel=0 on the next cycle.
- Fairness: channels 0–3 continuously valid with single-beat packets, data 8'hA0+k, out_ready=1.
  - out_sel sequence 0,1,2,3,0,1 with back-to-back out_valid.
  - out_data matches 8'hA0+out_sel.
- Packet lock: channel 2 sends 3 beats (last on beat 3) while channel 0 stays valid.
  - out_sel=2,2,2 then 0.
  - in_ready[0]=0 throughout the lock.
- Backpressure: hold out_ready=0 for 5 cycles with a beat loaded.
  - out_data/out_sel are stable and in_ready=0.
  - After release, the next beat appears with no loss or duplication.
- Locked bubble: channel 1 sends a non-last beat, then drops in_valid for 3 cycles while channel 3 is valid.
  - Channel 3 is not granted until channel 1 sends its last beat.
- Reset mid-packet: assert rst inside a channel 3 packet.
  - After reset: out_valid=0, the lock is cleared, and the next grant goes to channel 0 if valid.

Source files
------------

// File: rtl/rr_stream_mux4_pkg.sv
// Shared definitions for the 4:1 round-robin stream multiplexer.
// Holds channel-count constants, the arbiter FSM state type and a one-hot helper.
package rr_stream_mux4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_e;

  function automatic logic [NUM_CH-1:0] ch_mask(input logic [SEL_W-1:0] ch);
    logic [NUM_CH-1:0] m;
    m     = '0;
    m[ch] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_stream_mux4_pick.sv
// Combinational rotating-priority picker: the first request at or after ptr wins.
// Produces a one-hot grant, its binary index and an any-grant flag.
module rr_pick4
  import rr_stream_mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx_o = ptr_i;
    any_o = |req_i;
    // Walk from the farthest offset back to ptr so the nearest hit overwrites the rest.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_i[ptr_i + SEL_W'(i)]) begin
        idx_o = ptr_i + SEL_W'(i);
      end
    end
    grant_o = any_o ? ch_mask(idx_o) : '0;
  end

endmodule

// File: rtl/rr_stream_mux4.sv
// Four-to-one valid/ready stream merge with round-robin arbitration and packet locking.
// Output beats are registered and tagged with their source channel index.
module rr_stream_mux4
  import rr_stream_mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last
);

  state_e             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   lock_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SEL_W-1:0]   out_sel_q;
  logic               out_last_q;

  logic [NUM_CH-1:0]  req;
  logic [SEL_W-1:0]   pick_ptr;
  logic [NUM_CH-1:0]  grant;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               load;
  logic               accept;
  logic [WIDTH-1:0]   out_data_d;
  logic               out_last_d;

  // While locked only the owning channel may compete; everyone else is masked off.
  always_comb begin
    req      = in_valid;
    pick_ptr = ptr_q;
    if (state_q == ST_LOCK) begin
      req      = in_valid & ch_mask(lock_q);
      pick_ptr = lock_q;
    end
  end

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = grant & {NUM_CH{load & ~rst}};
  assign accept   = |in_ready;

  always_comb begin
    out_data_d = in_data[pick_idx*WIDTH +: WIDTH];
    out_last_d = in_last[pick_idx];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= pick_any;
        if (pick_any) begin
          out_data_q <= out_data_d;
          out_sel_q  <= pick_idx;
          out_last_q <= out_last_d;
        end
      end

      if (accept) begin
        unique case (state_q)
          ST_IDLE: begin
            if (out_last_d) begin
              ptr_q <= pick_idx + SEL_W'(1);
            end else begin
              state_q <= ST_LOCK;
              lock_q  <= pick_idx;
            end
          end
          ST_LOCK: begin
            if (out_last_d) begin
              state_q <= ST_IDLE;
              ptr_q   <= lock_q + SEL_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_stream_mux4.sv
// Directed bench for rr_stream_mux4: table of per-cycle vectors for reset, fairness and
// packet lock, followed by hand-written backpressure, locked-bubble and mid-packet reset sequences.
module tb_rr_stream_mux4;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_last;

  int n_checks = 0;
  int n_fail   = 0;

  rr_stream_mux4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    in_data[ch*W +: W] = d;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [1:0] sel,
                           input logic [7:0] data, input logic last);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    if (ov) begin
      check({tag, " out_sel"},  32'(out_sel),  32'(sel));
      check({tag, " out_data"}, 32'(out_data), 32'(data));
      check({tag, " out_last"}, 32'(out_last), 32'(last));
    end
  endtask

  vec_t vecs[13];

  initial begin
    // rst, valid, last, out_ready | in_ready, out_valid, sel, data, last
    vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1};
    // ptr=2: ch3 single beat moves ptr to 0, then ch2 opens a 3-beat packet
    vecs[8]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1};
    vecs[9]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0};
    vecs[10] = '{1'b0, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0};
    vecs[11] = '{1'b0, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1};
    vecs[12] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1};

    for (int k = 0; k < 4; k++) set_data(k, 8'hA0 + 8'(k));

    for (int i = 0; i < 13; i++) begin
      rst       = vecs[i].rst;
      in_valid  = vecs[i].valid;
      in_last   = vecs[i].last;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_sel", i),   32'(out_sel),   32'(vecs[i].exp_sel));
      check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d out_last", i),  32'(out_last),  32'(vecs[i].exp_last));
    end

    // Backpressure: ch0 beat A0 is held while ch1 waits.
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    in_last   = 4'b0010;
    set_data(1, 8'h5A);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'h0);
      tick();
      check_out($sformatf("bp%0d", c), 1'b1, 2'd0, 8'hA0, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release in_ready", 32'(in_ready), 32'h2);
    tick();
    check_out("bp_release", 1'b1, 2'd1, 8'h5A, 1'b1);
    in_valid = 4'b0000;
    #1;
    check("bp_drain in_ready", 32'(in_ready), 32'h0);
    tick();
    check("bp_drain out_valid", 32'(out_valid), 32'h0);

    // Locked bubble: ch1 opens a packet, stalls, ch3 must wait.
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    set_data(1, 8'h11);
    #1;
    check("bub_open in_ready", 32'(in_ready), 32'h2);
    tick();
    check_out("bub_open", 1'b1, 2'd1, 8'h11, 1'b0);
    in_valid = 4'b1000;
    in_last  = 4'b1000;
    set_data(3, 8'h33);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bub%0d in_ready", c), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("bub%0d out_valid", c), 32'(out_valid), 32'h0);
    end
    in_valid = 4'b1010;
    in_last  = 4'b1010;
    set_data(1, 8'h12);
    #1;
    check("bub_close in_ready", 32'(in_ready), 32'h2);
    tick();
    check_out("bub_close", 1'b1, 2'd1, 8'h12, 1'b1);
    in_valid = 4'b1000;
    #1;
    check("bub_ch3 in_ready", 32'(in_ready), 32'h8);
    tick();
    check_out("bub_ch3", 1'b1, 2'd3, 8'h33, 1'b1);

    // Reset inside a ch3 packet with a beat buffered; ch0 must win afterwards.
    in_valid = 4'b1000;
    in_last  = 4'b0000;
    set_data(3, 8'h44);
    #1;
    check("mrst_open in_ready", 32'(in_ready), 32'h8);
    tick();
    check_out("mrst_open", 1'b1, 2'd3, 8'h44, 1'b0);
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    in_last   = 4'b0001;
    set_data(0, 8'hA0);
    rst = 1'b1;
    #1;
    check("mrst_during in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mrst_during out_valid", 32'(out_valid), 32'h0);
    check("mrst_during out_sel", 32'(out_sel), 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mrst_after in_ready", 32'(in_ready), 32'h1);
    tick();
    check_out("mrst_after", 1'b1, 2'd0, 8'hA0, 1'b1);
    in_valid = 4'b0000;
    tick();
    check("mrst_idle out_valid", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
